// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state and grant
// encodings plus the width helper for the memory-latency wait counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Width of a down-counter able to hold MEM_LAT.
    function automatic int lat_cnt_w(input int mem_lat);
        return $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-requester grant logic: a lone requester always wins; on a tie the
// data port wins (FAIR=0) or the port not served last wins (FAIR=1).
import mem_arb_pkg::*;

module arb2_rr #(
    parameter int FAIR = 0
) (
    input  logic   if_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t grant
);

    // Pick the winner for the current IDLE cycle.
    always_comb begin
        grant = GNT_FETCH;
        if (if_req && d_req) begin
            if (FAIR != 0) begin
                grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
            end else begin
                grant = GNT_DATA;
            end
        end else if (d_req) begin
            grant = GNT_DATA;
        end else begin
            grant = GNT_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port
// memory. Each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> RESP, so an ack
// arrives MEM_LAT+2 cycles after the request is sampled in IDLE.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int FAIR    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = lat_cnt_w(MEM_LAT);

    arb_state_t        state_r,      state_nxt_s;
    grant_t            grant_r,      grant_nxt_s;
    grant_t            last_grant_r, last_grant_nxt_s;
    grant_t            arb_grant_s;
    logic              cmd_we_r,     cmd_we_nxt_s;
    logic [ADDR_W-1:0] cmd_addr_r,   cmd_addr_nxt_s;
    logic [DATA_W-1:0] cmd_wdata_r,  cmd_wdata_nxt_s;
    logic [CNT_W-1:0]  cnt_r,        cnt_nxt_s;
    logic              mem_en_r,     mem_en_nxt_s;
    logic              mem_we_r,     mem_we_nxt_s;
    logic              if_ack_r,     if_ack_nxt_s;
    logic              d_ack_r,      d_ack_nxt_s;
    logic [DATA_W-1:0] if_rdata_r,   if_rdata_nxt_s;
    logic [DATA_W-1:0] d_rdata_r,    d_rdata_nxt_s;

    arb2_rr #(
        .FAIR (FAIR)
    ) u_arb (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s)
    );

    // Next-state and next-register values; strobes default low so they pulse.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        cmd_we_nxt_s     = cmd_we_r;
        cmd_addr_nxt_s   = cmd_addr_r;
        cmd_wdata_nxt_s  = cmd_wdata_r;
        cnt_nxt_s        = cnt_r;
        mem_en_nxt_s     = 1'b0;
        mem_we_nxt_s     = 1'b0;
        if_ack_nxt_s     = 1'b0;
        d_ack_nxt_s      = 1'b0;
        if_rdata_nxt_s   = if_rdata_r;
        d_rdata_nxt_s    = d_rdata_r;
        case (state_r)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_nxt_s = arb_grant_s;
                    if (arb_grant_s == GNT_DATA) begin
                        cmd_we_nxt_s    = d_we;
                        cmd_addr_nxt_s  = d_addr;
                        cmd_wdata_nxt_s = d_wdata;
                        mem_we_nxt_s    = d_we;
                    end else begin
                        cmd_we_nxt_s    = 1'b0;
                        cmd_addr_nxt_s  = if_addr;
                        cmd_wdata_nxt_s = {DATA_W{1'b0}};
                        mem_we_nxt_s    = 1'b0;
                    end
                    mem_en_nxt_s = 1'b1;
                    state_nxt_s  = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                // The strobe is already on the bus this cycle; arm the latency count.
                cnt_nxt_s   = CNT_W'(MEM_LAT - 1);
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // Last WAIT cycle: read data is valid now, capture it with the ack.
                    state_nxt_s = RESP;
                    if (grant_r == GNT_DATA) begin
                        d_ack_nxt_s = 1'b1;
                        if (!cmd_we_r) begin
                            d_rdata_nxt_s = mem_rdata;
                        end else begin
                            d_rdata_nxt_s = d_rdata_r;
                        end
                    end else begin
                        if_ack_nxt_s   = 1'b1;
                        if_rdata_nxt_s = mem_rdata;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                // The served port still shows req here, so nothing is sampled.
                last_grant_nxt_s = grant_r;
                state_nxt_s      = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, command, counter and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= GNT_FETCH;
            last_grant_r <= GNT_FETCH;
            cmd_we_r     <= 1'b0;
            cmd_addr_r   <= {ADDR_W{1'b0}};
            cmd_wdata_r  <= {DATA_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            if_ack_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            cmd_we_r     <= cmd_we_nxt_s;
            cmd_addr_r   <= cmd_addr_nxt_s;
            cmd_wdata_r  <= cmd_wdata_nxt_s;
            cnt_r        <= cnt_nxt_s;
            mem_en_r     <= mem_en_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            if_ack_r     <= if_ack_nxt_s;
            d_ack_r      <= d_ack_nxt_s;
            if_rdata_r   <= if_rdata_nxt_s;
            d_rdata_r    <= d_rdata_nxt_s;
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = cmd_addr_r;
    assign mem_wdata = cmd_wdata_r;
    assign if_ack    = if_ack_r;
    assign d_ack     = d_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign if_stall  = if_req & ~if_ack_r;
    assign d_stall   = d_req & ~d_ack_r;

endmodule
